fp_addsub_sched: RTL and testbench

Round-robin scheduler that shares one multi-cycle fp_add_sub unit among NUM_REQ requesters.
- Accepts IEEE-754 single-precision add/sub requests on per-requester valid/ready ports.
- Before every operation it clears the unit and pulses its start. It holds the operands stable, waits for done (with a timeout), and returns the result on one shared response channel tagged with the requester ID.
- Sits between the issuing pipelines and the shared FP adder.

---
 rtl/fp_sched_pkg.sv | 17 +
 rtl/fp_addsub_sched_rr_arbiter.sv | 30 +++
 rtl/fp_addsub_sched.sv | 143 ++++++++++++++
 tb/tb_fp_addsub_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: shared FSM states, opcode values and FP field constants for the fp add/sub scheduler
package fp_sched_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int FP_W = 32;
  localparam int SIGN_BIT = 31;
  function automatic logic [FP_W-1:0] apply_op(input logic [FP_W-1:0] b, input logic op);
    return (op == OP_SUB) ? {~b[SIGN_BIT], b[SIGN_BIT-1:0]} : b;
  endfunction
endpackage

// File: rtl/fp_addsub_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last_grant, with wrap-around
//   req        : per-requester request vector
//   last_grant : index granted most recently (owned by the caller)
//   grant      : one-hot grant, zero when no request
//   grant_idx  : index of the granted requester
//   any_req    : at least one request is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);
  int t;
  assign any_req = |req;
  assign grant = any_req ? NUM_REQ'(1) << grant_idx : '0;
  // walking from the farthest offset down leaves the nearest requester after last_grant
  always_comb begin
    grant_idx = '0;
    t = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      t = int'(last_grant) + k;
      t = (t >= NUM_REQ) ? t - NUM_REQ : t;
      if (req[t[ID_W-1:0]]) grant_idx = t[ID_W-1:0];
    end
  end
endmodule

// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: round-robin scheduler sharing one multi-cycle fp add/sub unit among NUM_REQ requesters
//   req_valid/req_ready/req_a/req_b/req_op : per-requester request ports (ready is a one-cycle grant pulse)
//   resp_valid/resp_ready/resp_id/resp_result/resp_timeout : shared tagged response channel
//   busy : high outside IDLE
//   fu_clear/fu_start/fu_a1/fu_a2/fu_done/fu_result : interface to the shared unit
module fp_addsub_sched
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP_W-1:0]         resp_result,
  output logic                    resp_timeout,
  output logic                    busy,
  output logic                    fu_clear,
  output logic                    fu_start,
  output logic [FP_W-1:0]         fu_a1,
  output logic [FP_W-1:0]         fu_a2,
  input  logic                    fu_done,
  input  logic [FP_W-1:0]         fu_result
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [ID_W-1:0] last_q, last_d, resp_id_q, resp_id_d, grant_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic resp_valid_q, resp_valid_d, resp_timeout_q, resp_timeout_d;
  logic fu_clear_q, fu_clear_d, fu_start_q, fu_start_d;
  logic [FP_W-1:0] resp_result_q, resp_result_d, fu_a1_q, fu_a1_d, fu_a2_q, fu_a2_d;
  logic [FP_W-1:0] a_sel, b_sel;
  logic [NUM_REQ-1:0] grant;
  logic any_req, op_sel;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .last_grant(last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );
  assign req_ready = (state_q == IDLE && reset_n) ? grant : '0;
  assign busy = state_q != IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_timeout = resp_timeout_q;
  assign fu_clear = fu_clear_q;
  assign fu_start = fu_start_q;
  assign fu_a1 = fu_a1_q;
  assign fu_a2 = fu_a2_q;
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    op_sel = OP_ADD;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        a_sel = req_a[i*FP_W +: FP_W];
        b_sel = req_b[i*FP_W +: FP_W];
        op_sel = req_op[i];
      end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_id_d = resp_id_q;
    resp_result_d = resp_result_q;
    resp_timeout_d = resp_timeout_q;
    fu_clear_d = 1'b0;
    fu_start_d = 1'b0;
    fu_a1_d = fu_a1_q;
    fu_a2_d = fu_a2_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = CLEAR;
        last_d = grant_idx;
        resp_id_d = grant_idx;
        fu_clear_d = 1'b1;
        fu_a1_d = a_sel;
        fu_a2_d = apply_op(b_sel, op_sel);
      end
      CLEAR: begin
        state_d = START;
        fu_start_d = 1'b1;
      end
      START: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (fu_done || cnt_q == CNT_LAST) begin
        state_d = RESP;
        resp_valid_d = 1'b1;
        resp_timeout_d = !fu_done;
        resp_result_d = fu_done ? fu_result : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: if (resp_ready) begin
        state_d = IDLE;
        resp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= ID_W'(NUM_REQ - 1);
      cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q <= '0;
      resp_result_q <= '0;
      resp_timeout_q <= 1'b0;
      fu_clear_q <= 1'b0;
      fu_start_q <= 1'b0;
      fu_a1_q <= '0;
      fu_a2_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_timeout_q <= resp_timeout_d;
      fu_clear_q <= fu_clear_d;
      fu_start_q <= fu_start_d;
      fu_a1_q <= fu_a1_d;
      fu_a2_q <= fu_a2_d;
    end
  end
endmodule

// File: tb/tb_fp_addsub_sched.sv
// tb_fp_addsub_sched: directed vector bench for fp_addsub_sched with a 5-cycle unit model
module tb_fp_addsub_sched;
  localparam int N = 4;
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] a2;
    logic [31:0] res;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_op = '0;
  logic [N*32-1:0] req_a = '0, req_b = '0;
  logic resp_valid, resp_ready = 1'b0, resp_timeout, busy, fu_clear, fu_start;
  logic [1:0] resp_id;
  logic [31:0] resp_result, fu_a1, fu_a2, fu_result;
  logic fu_done = 1'b0;
  logic [31:0] fu_ret = '0;
  bit stuck = 1'b0, run = 1'b0;
  int lat = 0;
  int n_pass = 0, n_tot = 0, n_start = 0, n_resp = 0;
  vec_t vt[5];
  always #5 clk = ~clk;
  fp_addsub_sched #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_timeout(resp_timeout), .busy(busy),
    .fu_clear(fu_clear), .fu_start(fu_start), .fu_a1(fu_a1), .fu_a2(fu_a2),
    .fu_done(fu_done), .fu_result(fu_result)
  );
  // unit model: done rises 5 cycles after start, held until clear; result is 0 while not done
  assign fu_result = fu_done ? fu_ret : 32'h0;
  always @(posedge clk) begin
    if (fu_clear) begin
      fu_done <= 1'b0;
      run <= 1'b0;
    end else if (fu_start) begin
      run <= 1'b1;
      lat <= 0;
    end else if (run) begin
      lat <= lat + 1;
      if (lat == 3 && !stuck) begin
        fu_done <= 1'b1;
        run <= 1'b0;
      end
    end
  end
  always @(negedge clk) if (reset_n) begin
    if (fu_start) n_start++;
    if (resp_valid && resp_ready) n_resp++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask
  task automatic wait_grant;
    int c;
    c = 0;
    #1;
    while (req_ready == '0 && c < 20) begin
      @(posedge clk);
      #2;
      c++;
    end
  endtask
  task automatic wait_resp(output int c);
    c = 0;
    while (!resp_valid && c < 40) begin
      tick;
      c++;
    end
  endtask
  task automatic do_op(input string nm, input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] a2, input logic [31:0] ret,
                       input logic [31:0] res, input logic to, input int exp_lat);
    int c;
    logic [N-1:0] oh;
    oh = N'(1) << id;
    fu_ret = ret;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_op[id] = op;
    req_valid = oh;
    wait_grant;
    chk({nm, "_grant"}, 64'(req_ready), 64'(oh));
    tick;
    req_valid = '0;
    chk({nm, "_clear"}, {61'd0, fu_clear, fu_start, busy}, 64'b101);
    chk({nm, "_operands"}, {fu_a1, fu_a2}, {a, a2});
    tick;
    chk({nm, "_start"}, {62'd0, fu_clear, fu_start}, 64'b01);
    wait_resp(c);
    chk({nm, "_latency"}, 64'(c), 64'(exp_lat));
    chk({nm, "_resp"}, {60'd0, resp_valid, resp_id, resp_timeout}, {60'd0, 1'b1, 2'(id), to});
    chk({nm, "_result"}, {32'd0, resp_result}, {32'd0, res});
    chk({nm, "_held_a"}, {32'd0, fu_a1}, {32'd0, a});
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk({nm, "_idle"}, {62'd0, resp_valid, busy}, 64'd0);
  endtask
  initial begin
    int c, s0, r0, bad;
    logic [31:0] h_res;
    logic [1:0] h_id;
    logic h_to;
    vt[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000};
    vt[1] = '{2, 32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000};
    vt[2] = '{3, 32'h40000000, 32'h40000000, 1'b0, 32'h40000000, 32'h40800000};
    vt[3] = '{1, 32'h3F800000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h00000000};
    vt[4] = '{0, 32'h40000000, 32'hC0000000, 1'b1, 32'h40000000, 32'h40800000};
    do_reset;
    chk("rst_ctl", {req_ready, resp_valid, resp_id, resp_timeout, busy, fu_clear, fu_start}, 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_fu_a", {fu_a1, fu_a2}, 64'd0);
    for (int i = 0; i < 5; i++)
      do_op($sformatf("vec%0d", i), vt[i].id, vt[i].a, vt[i].b, vt[i].op, vt[i].a2,
            vt[i].res, vt[i].res, 1'b0, 6);
    // round robin with every requester valid and responses always accepted
    do_reset;
    s0 = n_start;
    r0 = n_resp;
    req_valid = '1;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_grant;
      chk($sformatf("rr_grant%0d", i), 64'(req_ready), 64'(N'(1) << (i % N)));
      tick;
      if (i == 4) req_valid = '0;
      chk($sformatf("rr_pulse%0d", i), 64'(req_ready), 64'd0);
    end
    wait_resp(c);
    tick;
    resp_ready = 1'b0;
    chk("rr_starts", 64'(n_start - s0), 64'd5);
    chk("rr_resps", 64'(n_resp - r0), 64'd5);
    // backpressure on requester 1 while requester 0 waits
    do_reset;
    fu_ret = 32'h12345678;
    req_valid = 4'b0010;
    wait_grant;
    chk("bp_grant", 64'(req_ready), 64'b0010);
    tick;
    req_valid = 4'b0001;
    wait_resp(c);
    h_res = resp_result;
    h_id = resp_id;
    h_to = resp_timeout;
    chk("bp_resp", {h_res, 29'd0, h_id, h_to}, {32'h12345678, 29'd0, 2'd1, 1'b0});
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (!resp_valid || resp_result != h_res || resp_id != h_id || resp_timeout != h_to ||
          req_ready != '0 || fu_start) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("bp_next_grant", {59'd0, resp_valid, req_ready}, 64'b00001);
    tick;
    req_valid = '0;
    wait_resp(c);
    chk("bp_next_resp", 64'(resp_id), 64'd0);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    // unit never finishes: abort after 16 WAIT cycles, then a normal operation
    stuck = 1'b1;
    do_op("tmo", 3, 32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 32'hAAAA5555, 32'h0, 1'b1, 17);
    stuck = 1'b0;
    do_op("after_tmo", 2, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000, 32'h40400000, 1'b0, 6);
    // asynchronous reset in the middle of WAIT
    do_reset;
    do_op("pre", 0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 6);
    fu_ret = 32'h55555555;
    req_valid = 4'b0100;
    wait_grant;
    chk("mid_grant", 64'(req_ready), 64'b0100);
    tick;
    tick;
    tick;
    tick;
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {req_ready, resp_valid, resp_id, resp_timeout, busy, fu_clear, fu_start}, 64'd0);
    chk("mid_rst_fu_a", {fu_a1, fu_a2}, 64'd0);
    req_valid = 4'b0101;
    tick;
    reset_n = 1'b1;
    #1;
    chk("mid_regrant", {59'd0, resp_valid, req_ready}, 64'b00001);
    tick;
    req_valid = '0;
    chk("mid_reclear", {62'd0, fu_clear, fu_start}, 64'b10);
    wait_resp(c);
    chk("mid_resp", {resp_result, 29'd0, resp_id, resp_timeout}, {32'h55555555, 32'd0});
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
